// File: rtl/lenet_axil_stream_loader.sv
// rtl/lenet_axil_stream_loader.sv - AXI4-Lite register front end feeding per-channel FWFT stream FIFOs
// Also owns the control/status/result/count registers and the completion interrupt.
module lenet_axil_stream_loader #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int N_CH               = 3,
   parameter int FIFO_DEPTH         = 16,
   parameter int RESULT_W           = 4
) (
   input  logic                                 S_AXI_ACLK,
   input  logic                                 S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
   input  logic [2:0]                           S_AXI_AWPROT,
   input  logic                                 S_AXI_AWVALID,
   output logic                                 S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
   input  logic                                 S_AXI_WVALID,
   output logic                                 S_AXI_WREADY,
   output logic [1:0]                           S_AXI_BRESP,
   output logic                                 S_AXI_BVALID,
   input  logic                                 S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
   input  logic [2:0]                           S_AXI_ARPROT,
   input  logic                                 S_AXI_ARVALID,
   output logic                                 S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
   output logic [1:0]                           S_AXI_RRESP,
   output logic                                 S_AXI_RVALID,
   input  logic                                 S_AXI_RREADY,
   output logic [N_CH*C_S_AXI_DATA_WIDTH-1:0]   ch_tdata,
   output logic [N_CH-1:0]                      ch_tvalid,
   input  logic [N_CH-1:0]                      ch_tready,
   output logic                                 core_start,
   output logic                                 core_clr,
   input  logic                                 core_done,
   input  logic [RESULT_W-1:0]                  core_result,
   output logic                                 irq
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   logic                clk;
   logic                rst_n;
   logic                aw_rdy;
   logic                wr_hs;
   logic                ar_hs;
   logic [IW-1:0]       widx;
   logic [IW-1:0]       ridx;
   logic [1:0]          ctrl;
   logic                sclr;
   logic                done;
   logic [RESULT_W-1:0] result;
   logic [31:0]         img_cnt;
   logic [15:0]         ovf_cnt;
   logic [N_CH-1:0]     push_req;
   logic [N_CH-1:0]     empty;
   logic [N_CH-1:0]     full;
   logic                push_err;
   logic                ctrl_wr;
   logic                start_fall;
   logic                done_evt;
   logic [DW-1:0]       status_word;
   logic [DW-1:0]       rd_mux;
   logic                unused_inputs;

   assign clk   = S_AXI_ACLK;
   assign rst_n = S_AXI_ARESETN;
   assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                            S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign widx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign ridx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign wr_hs = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
   assign ar_hs = S_AXI_ARREADY & S_AXI_ARVALID;

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = aw_rdy;
   assign S_AXI_RRESP   = 2'b00;

   // Write channel: single outstanding transaction, ready pulses for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_rdy       <= 1'b0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= 2'b00;
      end else begin
         aw_rdy <= S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~aw_rdy;
         if (wr_hs) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= push_err ? 2'b10 : 2'b00;
         end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
      end else begin
         S_AXI_ARREADY <= S_AXI_ARVALID & ~S_AXI_RVALID & ~S_AXI_ARREADY;
         if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
         end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [PW-1:0] wptr;
      logic [PW-1:0] rptr;
      logic [DW-1:0] mem [FIFO_DEPTH];
      logic          push_ok;
      logic          pop;

      assign push_req[k] = wr_hs && (widx == IW'(k + 1));
      assign empty[k]    = (wptr == rptr);
      assign full[k]     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      // Full is judged on pre-pop pointers, so a push meeting a pop on a full FIFO is dropped.
      assign push_ok     = push_req[k] & ~full[k] & ~sclr;
      assign pop         = ch_tvalid[k] & ch_tready[k];
      assign ch_tvalid[k] = ~empty[k];
      assign ch_tdata[k*DW +: DW] = mem[rptr[AW-1:0]];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
         end else if (sclr) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop)     rptr <= rptr + PW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (push_ok) mem[wptr[AW-1:0]] <= S_AXI_WDATA;
      end
   end

   assign push_err   = |(push_req & (full | {N_CH{sclr}}));
   assign ctrl_wr    = wr_hs && (widx == IW'(0));
   assign start_fall = ctrl_wr & ctrl[0] & ~S_AXI_WDATA[0];
   assign done_evt   = core_done & ctrl[0] & ~start_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl    <= 2'b00;
         sclr    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         img_cnt <= '0;
         ovf_cnt <= '0;
      end else begin
         if (ctrl_wr) ctrl <= S_AXI_WDATA[1:0];
         if (wr_hs && (widx == IW'(7))) sclr <= S_AXI_WDATA[0];
         if (sclr) begin
            done    <= 1'b0;
            result  <= '0;
            img_cnt <= '0;
            ovf_cnt <= '0;
         end else begin
            if (start_fall) begin
               done <= 1'b0;
            end else if (done_evt) begin
               done   <= 1'b1;
               result <= core_result;
               if (img_cnt != 32'hFFFF_FFFF) img_cnt <= img_cnt + 32'd1;
            end
            if (|(push_req & full) && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      status_word    = '0;
      status_word[0] = done;
      for (int k = 0; k < N_CH; k++) begin
         status_word[8 + k]  = empty[k];
         status_word[16 + k] = full[k];
      end
   end

   always_comb begin
      rd_mux = '0;
      case (ridx)
         IW'(0):  rd_mux = DW'(ctrl);
         IW'(4):  rd_mux = status_word;
         IW'(5):  rd_mux = DW'(done);
         IW'(6):  rd_mux = DW'(result);
         IW'(7):  rd_mux = DW'(sclr);
         IW'(8):  rd_mux = DW'(img_cnt);
         IW'(9):  rd_mux = DW'(ovf_cnt);
         default: rd_mux = '0;
      endcase
   end

   assign core_start = ctrl[0];
   assign core_clr   = sclr;
   assign irq        = ctrl[1] & done;

endmodule

// File: tb/tb_lenet_axil_stream_loader.sv
// tb/tb_lenet_axil_stream_loader.sv - scoreboard bench for lenet_axil_stream_loader
module tb_lenet_axil_stream_loader;

   localparam int N_CH  = 3;
   localparam int DEPTH = 16;

   logic               clk;
   logic               rst_n;
   logic [5:0]         awaddr;
   logic [2:0]         awprot;
   logic               awvalid;
   logic               awready;
   logic [31:0]        wdata;
   logic [3:0]         wstrb;
   logic               wvalid;
   logic               wready;
   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;
   logic [5:0]         araddr;
   logic [2:0]         arprot;
   logic               arvalid;
   logic               arready;
   logic [31:0]        rdata;
   logic [1:0]         rresp;
   logic               rvalid;
   logic               rready;
   logic [N_CH*32-1:0] ch_tdata;
   logic [N_CH-1:0]    ch_tvalid;
   logic [N_CH-1:0]    ch_tready;
   logic               core_start;
   logic               core_clr;
   logic               core_done;
   logic [3:0]         core_result;
   logic               irq;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mq [N_CH][$];
   logic [1:0]  exp_b [$];
   logic [31:0] exp_r [$];
   logic [1:0]  m_ctrl;
   logic        m_sclr;
   logic        m_done;
   logic [3:0]  m_result;
   logic [31:0] m_img;
   logic [15:0] m_ovf;

   lenet_axil_stream_loader dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR (awaddr),
      .S_AXI_AWPROT (awprot),
      .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA  (wdata),
      .S_AXI_WSTRB  (wstrb),
      .S_AXI_WVALID (wvalid),
      .S_AXI_WREADY (wready),
      .S_AXI_BRESP  (bresp),
      .S_AXI_BVALID (bvalid),
      .S_AXI_BREADY (bready),
      .S_AXI_ARADDR (araddr),
      .S_AXI_ARPROT (arprot),
      .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA  (rdata),
      .S_AXI_RRESP  (rresp),
      .S_AXI_RVALID (rvalid),
      .S_AXI_RREADY (rready),
      .ch_tdata     (ch_tdata),
      .ch_tvalid    (ch_tvalid),
      .ch_tready    (ch_tready),
      .core_start   (core_start),
      .core_clr     (core_clr),
      .core_done    (core_done),
      .core_result  (core_result),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N_CH; k++) mq[k].delete();
      m_ctrl = 0; m_sclr = 0; m_done = 0; m_result = 0; m_img = 0; m_ovf = 0;
   endtask

   function automatic logic [31:0] model_read(input int idx);
      logic [31:0] s;
      case (idx)
         0: return 32'(m_ctrl);
         4: begin
            s = 32'(m_done);
            for (int k = 0; k < N_CH; k++) begin
               s[8 + k]  = (mq[k].size() == 0);
               s[16 + k] = (mq[k].size() == DEPTH);
            end
            return s;
         end
         5: return 32'(m_done);
         6: return 32'(m_result);
         7: return 32'(m_sclr);
         8: return m_img;
         9: return 32'(m_ovf);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [1:0] model_write(input int idx, input logic [31:0] d);
      if (idx >= 1 && idx <= N_CH) begin
         if (m_sclr) return 2'b10;
         if (mq[idx-1].size() == DEPTH) begin
            if (m_ovf != 16'hFFFF) m_ovf++;
            return 2'b10;
         end
         mq[idx-1].push_back(d);
      end else if (idx == 0) begin
         if (m_ctrl[0] && !d[0]) m_done = 0;
         m_ctrl = d[1:0];
      end else if (idx == 7) begin
         m_sclr = d[0];
         if (m_sclr) begin
            for (int k = 0; k < N_CH; k++) mq[k].delete();
            m_done = 0; m_result = 0; m_img = 0; m_ovf = 0;
         end
      end
      return 2'b00;
   endfunction

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] d,
                            input logic [N_CH-1:0] pop_mask, input bit wait_b);
      int n;
      logic [N_CH-1:0] saved;
      awaddr = addr; wdata = d; awvalid = 1; wvalid = 1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!awready && n < 50);
      if (!awready) begin
         check("aw_timeout", 32'(awready), 32'd1);
         awvalid = 0; wvalid = 0;
         return;
      end
      exp_b.push_back(model_write(int'(addr[5:2]), d));
      saved = ch_tready;
      ch_tready = ch_tready | pop_mask;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      ch_tready = saved;
      if (wait_b) begin
         n = 0;
         while (bvalid && n < 50) begin @(posedge clk); #1; n++; end
         if (bvalid) check("b_timeout", 32'(bvalid), 32'd0);
      end
   endtask

   task automatic axi_read(input logic [5:0] addr);
      int n;
      araddr = addr; arvalid = 1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!arready && n < 50);
      if (!arready) begin
         check("ar_timeout", 32'(arready), 32'd1);
         arvalid = 0;
         return;
      end
      exp_r.push_back(model_read(int'(addr[5:2])));
      @(posedge clk); #1;
      arvalid = 0;
      n = 0;
      while (rvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (rvalid) check("r_timeout", 32'(rvalid), 32'd0);
   endtask

   task automatic pulse_done(input logic [3:0] r);
      core_done = 1; core_result = r;
      if (m_ctrl[0] && !m_sclr) begin
         m_done = 1; m_result = r;
         if (m_img != 32'hFFFF_FFFF) m_img++;
      end
      @(posedge clk); #1;
      core_done = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: pops expected responses whenever the DUT completes a handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (bvalid && bready) begin
            if (exp_b.size() == 0) check("bresp_unexpected", 32'(bvalid), 32'd0);
            else check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
         end
         if (rvalid && rready) begin
            if (exp_r.size() == 0) check("rdata_unexpected", 32'(rvalid), 32'd0);
            else begin
               check("rdata", rdata, exp_r.pop_front());
               check("rresp", 32'(rresp), 32'd0);
            end
         end
         for (int k = 0; k < N_CH; k++) begin
            if (ch_tvalid[k] && ch_tready[k]) begin
               if (mq[k].size() == 0) check($sformatf("stream%0d_extra", k), 32'(ch_tvalid[k]), 32'd0);
               else check($sformatf("stream%0d_data", k), ch_tdata[k*32 +: 32], mq[k].pop_front());
            end
         end
      end
   end

   task automatic check_drained(input string name);
      for (int k = 0; k < N_CH; k++) begin
         check($sformatf("%s_tvalid%0d", name, k), 32'(ch_tvalid[k]), 32'd0);
         check($sformatf("%s_model%0d", name, k), 32'(mq[k].size()), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] d;
      int ch;
      rst_n = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 4'hF; wvalid = 0;
      bready = 1; araddr = 0; arprot = 0; arvalid = 0; rready = 1;
      ch_tready = '0; core_done = 0; core_result = 0;
      model_reset();
      cycles(3);
      check("rst_awready", 32'(awready), 0);
      check("rst_bvalid", 32'(bvalid), 0);
      check("rst_arready", 32'(arready), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_tvalid", 32'(ch_tvalid), 0);
      check("rst_core", {29'd0, core_start, core_clr, irq}, 0);
      rst_n = 1;
      cycles(1);

      // 1: every register after reset
      for (int a = 0; a < 16; a++) axi_read(6'(a * 4));
      axi_read(6'h10);
      check("status_reset_const", model_read(4), 32'h0000_0700);

      // 2: overflow of FIFO 0 then ordered drain
      for (int i = 0; i < 17; i++) axi_write(6'h04, 32'h100 + 32'(i), '0, 1);
      axi_read(6'h24);
      axi_read(6'h10);
      ch_tready[0] = 1;
      cycles(15);
      check("fifo0_tvalid_15", 32'(ch_tvalid[0]), 1);
      cycles(1);
      check("fifo0_tvalid_16", 32'(ch_tvalid[0]), 0);
      check("fifo0_model_empty", 32'(mq[0].size()), 0);
      ch_tready[0] = 0;

      // 3: completion and interrupt
      axi_write(6'h00, 32'd1, '0, 1);
      check("core_start", 32'(core_start), 1);
      pulse_done(4'd7);
      axi_read(6'h14); axi_read(6'h18); axi_read(6'h20);
      check("irq_disabled", 32'(irq), 0);
      axi_write(6'h00, 32'd3, '0, 1);
      check("irq_enabled", 32'(irq), 1);
      axi_write(6'h00, 32'd0, '0, 1);
      axi_read(6'h14);
      check("irq_cleared", 32'(irq), 0);
      pulse_done(4'd5);
      axi_read(6'h18);

      // 4: push meets pop on a full FIFO
      for (int i = 0; i < DEPTH; i++) axi_write(6'h0C, $urandom, '0, 1);
      axi_write(6'h0C, $urandom, 3'b100, 1);
      axi_read(6'h10);
      axi_read(6'h24);
      ch_tready[2] = 1;
      cycles(20);
      check_drained("fifo2");
      ch_tready = '0;

      // Random traffic with random stalls
      for (int i = 0; i < 60; i++) begin
         ch_tready = N_CH'($urandom_range(0, 7));
         ch = $urandom_range(0, N_CH - 1);
         d = $urandom;
         axi_write(6'(4 + 4 * ch), d, '0, 1);
      end
      ch_tready = '0;
      axi_read(6'h10);
      axi_read(6'h24);
      ch_tready = '1;
      cycles(3 * DEPTH);
      check_drained("rand");
      ch_tready = '0;

      // 5: soft clear
      axi_write(6'h00, 32'd1, '0, 1);
      for (int i = 0; i < 4; i++) pulse_done(4'($urandom));
      axi_write(6'h04, $urandom, '0, 1);
      axi_write(6'h08, $urandom, '0, 1);
      axi_read(6'h20);
      axi_write(6'h1C, 32'd0, '0, 1);
      axi_write(6'h1C, 32'd1, '0, 1);
      check("core_clr_high", 32'(core_clr), 1);
      axi_write(6'h04, $urandom, '0, 1);
      axi_read(6'h24);
      axi_read(6'h20);
      axi_write(6'h1C, 32'd0, '0, 1);
      check("core_clr_low", 32'(core_clr), 0);
      for (int a = 4; a < 10; a++) axi_read(6'(a * 4));
      check_drained("sclr");
      axi_write(6'h00, 32'd0, '0, 1);

      // 6: reset with a pending write response
      bready = 0;
      axi_write(6'h08, $urandom, '0, 0);
      check("bvalid_pending", 32'(bvalid), 1);
      rst_n = 0;
      #1;
      check("bvalid_async_clear", 32'(bvalid), 0);
      exp_b.delete();
      model_reset();
      cycles(2);
      rst_n = 1;
      bready = 1;
      cycles(1);
      check_drained("reset");
      axi_read(6'h10);
      check("exp_b_empty", 32'(exp_b.size()), 0);
      check("exp_r_empty", 32'(exp_r.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
